// File: rtl/pwm_pkg.sv
// Shared constants, types and level/mask helpers for the PWM output stage.
package pwm_pkg;

  localparam int PWM_STEPS = 256;
  localparam int DUTY_W    = 8;
  localparam logic [DUTY_W-1:0] DUTY_FULL = 8'hFF;
  localparam int NUM_CH    = 16;

  typedef logic [DUTY_W-1:0] duty_t;
  typedef logic [NUM_CH-1:0] ch_mask_t;

  // Full duty is a special case so the waveform never dips low at the wrap.
  function automatic logic pwm_level(input duty_t duty, input duty_t step);
    return (duty == DUTY_FULL) || (step < duty);
  endfunction

  function automatic ch_mask_t chan_mask(input ch_mask_t en_out,
                                         input ch_mask_t en_pwm,
                                         input logic     lvl);
    return en_out & (~en_pwm | {NUM_CH{lvl}});
  endfunction

endpackage

// File: rtl/pwm_if.sv
// Register-block to output-stage bundle: enables and duty in, channel outputs out.
interface pwm_if;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic [7:0] out_7_0;
  logic [7:0] out_15_8;
  logic       period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    output pwm_duty_cycle,
    input  out_7_0, out_15_8, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    input  pwm_duty_cycle,
    output out_7_0, out_15_8, period_start
  );
endinterface

// File: rtl/pwm_timebase.sv
// Prescaled 8-bit step counter with double-buffered duty; exports the PWM level
// of the upcoming cycle so registered outputs line up with period_start.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 3000
) (
  input  logic  clk,
  input  logic  rst,
  input  duty_t i_duty,
  output logic  o_lvl_next,
  output logic  o_wrap
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam duty_t         STEP_LAST  = duty_t'(PWM_STEPS - 1);

  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_next;
  duty_t         r_cnt;
  duty_t         w_cnt_next;
  duty_t         r_duty_sh;
  duty_t         w_duty_next;
  logic          w_tick;

  // Next-state logic for prescaler, step counter and duty shadow.
  always_comb begin
    w_tick = (r_presc == PRESC_LAST);
    o_wrap = w_tick && (r_cnt == STEP_LAST);
    if (w_tick) begin
      w_presc_next = '0;
      w_cnt_next   = r_cnt + 8'd1;
    end else begin
      w_presc_next = r_presc + PW'(1);
      w_cnt_next   = r_cnt;
    end
    if (o_wrap) begin
      w_duty_next = i_duty;
    end else begin
      w_duty_next = r_duty_sh;
    end
    o_lvl_next = pwm_level(w_duty_next, w_cnt_next);
  end

  // Time-base state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc   <= '0;
      r_cnt     <= 8'h00;
      r_duty_sh <= 8'h00;
    end else begin
      r_presc   <= w_presc_next;
      r_cnt     <= w_cnt_next;
      r_duty_sh <= w_duty_next;
    end
  end

endmodule

// File: rtl/pwm_output_stage.sv
// Sixteen-channel output stage: per-channel off / on / PWM masking of a shared
// prescaled PWM waveform, with registered outputs and a period-start strobe.
module pwm_output_stage
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 3000
) (
  input  logic clk,
  input  logic rst,
  pwm_if.slave bus
);

  logic     w_lvl_next;
  logic     w_wrap;
  ch_mask_t w_en_out;
  ch_mask_t w_en_pwm;
  ch_mask_t w_out_next;
  ch_mask_t r_out;
  logic     r_period_start;

  pwm_timebase #(
    .CLK_DIV (CLK_DIV)
  ) u_timebase (
    .clk        (clk),
    .rst        (rst),
    .i_duty     (bus.pwm_duty_cycle),
    .o_lvl_next (w_lvl_next),
    .o_wrap     (w_wrap)
  );

  assign w_en_out   = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign w_en_pwm   = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
  assign w_out_next = chan_mask(w_en_out, w_en_pwm, w_lvl_next);

  // Output and strobe registers; strobe marks the first cycle after the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out          <= 16'h0000;
      r_period_start <= 1'b0;
    end else begin
      r_out          <= w_out_next;
      r_period_start <= w_wrap;
    end
  end

  assign bus.out_7_0      = r_out[7:0];
  assign bus.out_15_8     = r_out[15:8];
  assign bus.period_start = r_period_start;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed bench for pwm_output_stage (CLK_DIV=4) with a cycle-index reference model.
module tb_pwm_output_stage;
  localparam int CLK_DIV = 4;
  localparam int PERIOD  = 256 * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pwm_if u_if();

  pwm_output_stage #(.CLK_DIV(CLK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int printed  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (printed < 40) begin
        printed++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // Reference model: cycle index since reset, duty per period taken at the wrap cycle.
  bit          m_valid = 1'b0;
  int          m_c;
  logic [7:0]  m_duty;
  logic [15:0] m_out;
  logic        m_ps;

  always @(posedge clk) begin
    logic [15:0] eo;
    logic [15:0] ep;
    int          step;
    logic        lvl;
    if (rst) begin
      m_valid = 1'b1;
      m_c     = 0;
      m_duty  = 8'h00;
      m_out   = 16'h0000;
      m_ps    = 1'b0;
    end else if (m_valid) begin
      if (m_c % PERIOD == PERIOD - 1) m_duty = u_if.pwm_duty_cycle;
      m_c  = m_c + 1;
      step = (m_c / CLK_DIV) % 256;
      lvl  = (m_duty == 8'hFF) || (step < int'(m_duty));
      eo   = {u_if.en_reg_out_15_8, u_if.en_reg_out_7_0};
      ep   = {u_if.en_reg_pwm_15_8, u_if.en_reg_pwm_7_0};
      for (int ch = 0; ch < 16; ch++) begin
        if (!eo[ch])      m_out[ch] = 1'b0;
        else if (!ep[ch]) m_out[ch] = 1'b1;
        else              m_out[ch] = lvl;
      end
      m_ps = (m_c % PERIOD == 0);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_out_7_0", {24'd0, u_if.out_7_0}, {24'd0, m_out[7:0]});
      chk("model_out_15_8", {24'd0, u_if.out_15_8}, {24'd0, m_out[15:8]});
      chk("model_period_start", {31'd0, u_if.period_start}, {31'd0, m_ps});
    end
  end

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    u_if.en_reg_out_7_0  = eo[7:0];
    u_if.en_reg_out_15_8 = eo[15:8];
    u_if.en_reg_pwm_7_0  = ep[7:0];
    u_if.en_reg_pwm_15_8 = ep[15:8];
  endtask

  task automatic wait_ps(input int bound);
    bit found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (u_if.period_start === 1'b1) found = 1'b1;
    end
    if (!found) chk("wait_period_start_timeout", 32'd0, 32'd1);
  endtask

  // Samples one full period starting at the current negedge, ends on the next period's first negedge.
  task automatic measure(input bit expect_ps, input int ch, input int change_at,
                         input logic [7:0] new_duty, output int hi);
    logic [15:0] o;
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 0 && expect_ps) chk("period_start_at_start", {31'd0, u_if.period_start}, 32'd1);
      o = {u_if.out_15_8, u_if.out_7_0};
      if (ch < 0) hi += (o != 16'h0000) ? 1 : 0;
      else        hi += o[ch] ? 1 : 0;
      if (i == change_at) u_if.pwm_duty_cycle = new_duty;
    end
    @(negedge clk);
  endtask

  initial begin
    int hi;
    int total;
    set_en(16'h0000, 16'h0000);
    u_if.pwm_duty_cycle = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_out", {16'd0, u_if.out_15_8, u_if.out_7_0}, 32'd0);
    chk("reset_period_start", {31'd0, u_if.period_start}, 32'd0);
    rst = 1'b0;

    set_en(16'h0001, 16'h0001);
    u_if.pwm_duty_cycle = 8'h80;
    wait_ps(PERIOD + 80);
    measure(1'b1, 0, -1, 8'h00, hi);
    chk("duty80_high_clks", hi, 32'd512);
    chk("period_start_1024", {31'd0, u_if.period_start}, 32'd1);

    u_if.pwm_duty_cycle = 8'h00;
    measure(1'b1, 0, -1, 8'h00, hi);
    chk("duty_old_held", hi, 32'd512);
    measure(1'b1, 0, -1, 8'h00, hi);
    chk("duty00_low", hi, 32'd0);

    u_if.pwm_duty_cycle = 8'hFF;
    measure(1'b1, 0, -1, 8'h00, hi);
    chk("duty00_before_ff", hi, 32'd0);
    total = 0;
    for (int p = 0; p < 3; p++) begin
      measure(1'b1, 0, -1, 8'h00, hi);
      total += hi;
    end
    chk("dutyFF_three_periods", total, 32'd3072);

    set_en(16'hFFFF, 16'h0000);
    @(negedge clk);
    chk("static_on_7_0", {24'd0, u_if.out_7_0}, 32'h0000_00FF);
    chk("static_on_15_8", {24'd0, u_if.out_15_8}, 32'h0000_00FF);
    u_if.en_reg_out_15_8 = 8'h00;
    @(negedge clk);
    chk("off_15_8", {24'd0, u_if.out_15_8}, 32'd0);
    chk("still_on_7_0", {24'd0, u_if.out_7_0}, 32'h0000_00FF);

    set_en(16'h0001, 16'h0001);
    u_if.pwm_duty_cycle = 8'h40;
    wait_ps(PERIOD + 80);
    measure(1'b1, 0, 64, 8'hC0, hi);
    chk("duty40_kept_after_change", hi, 32'd256);
    measure(1'b1, 0, -1, 8'h00, hi);
    chk("dutyC0_next_period", hi, 32'd768);

    set_en(16'hFFFF, 16'hFFFF);
    u_if.pwm_duty_cycle = 8'hFF;
    wait_ps(PERIOD + 80);
    repeat (448) @(negedge clk);
    chk("pre_reset_all_high", {16'd0, u_if.out_15_8, u_if.out_7_0}, 32'h0000_FFFF);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset_out_zero", {16'd0, u_if.out_15_8, u_if.out_7_0}, 32'd0);
    chk("mid_reset_no_strobe", {31'd0, u_if.period_start}, 32'd0);
    rst = 1'b0;
    measure(1'b0, 0, -1, 8'h00, hi);
    chk("post_reset_first_low", hi, 32'd0);
    measure(1'b1, 0, -1, 8'h00, hi);
    chk("post_reset_second_high", hi, 32'd1024);

    set_en(16'h0000, 16'hFFFF);
    u_if.pwm_duty_cycle = 8'h80;
    wait_ps(PERIOD + 80);
    measure(1'b1, -1, -1, 8'h00, hi);
    chk("pwm_masked_by_en_out", hi, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_output_stage.md
# pwm_output_stage

Drives the sixteen design outputs from the SPI-written control registers. It takes the output-enable, PWM-enable and duty-cycle registers produced by the SPI register block and generates one shared 8-bit PWM waveform from a prescaled time base. Each channel is driven low, constant high, or PWM according to its enable bits. Duty-cycle updates are double-buffered so a period is never truncated or glitched.

## Interface
Parameters:
- CLK_DIV, default 3000: clk cycles per PWM step; must be ≥ 1. PWM period = 256 × CLK_DIV clk cycles.

Ports:
- clk  input  1  system clock; the only clock
- rst  input  1  reset, synchronous, active-high
- en_reg_out_7_0  input  8  output enable, channels 7..0
- en_reg_out_15_8  input  8  output enable, channels 15..8
- en_reg_pwm_7_0  input  8  PWM select, channels 7..0
- en_reg_pwm_15_8  input  8  PWM select, channels 15..8
- pwm_duty_cycle  input  8  requested duty (0x00–0xFF)
- out_7_0  output  8  registered channel outputs 7..0
- out_15_8  output  8  registered channel outputs 15..8
- period_start  output  1  one-clk strobe on the first cycle of each PWM period

## Operation
- Prescaler:
  - Counts 0..CLK_DIV−1 and wraps.
  - `tick` is asserted in the cycle where the count equals CLK_DIV−1.
  - With CLK_DIV=1, `tick` is asserted every cycle.
- Step counter `pwm_cnt`:
  - 8 bits; increments on `tick`, wrapping 255→0.
  - A `tick` with pwm_cnt==255 is the period wrap.
- Duty shadow `duty_sh`:
  - Loaded from pwm_duty_cycle only on the period wrap cycle.
  - Never changes mid-period.
- PWM level:
  - `pwm_lvl = (duty_sh == 8'hFF) | (pwm_cnt < duty_sh)`.
  - Duty 0x00 gives constant low.
  - Duty 0xFF gives constant high (special case, not 255/256).
  - Other duty values give high for duty × CLK_DIV clks per period.
- Per channel i, next output value:
  - en_out[i]=0: 0
  - en_out[i]=1 and en_pwm[i]=0: 1
  - en_out[i]=1 and en_pwm[i]=1: pwm_lvl
- en_pwm has no effect while en_out is 0.
- Enable inputs are sampled every cycle and are not shadowed.
- Inputs are already in the clk domain and stable per cycle, so no synchronisers are needed.

## Timing
- Reset values (applied on the clk edge where rst=1):
  - prescaler = 0, pwm_cnt = 0, duty_sh = 0x00
  - out_7_0 = 0x00, out_15_8 = 0x00, period_start = 0
- After reset deasserts, the first period begins at pwm_cnt=0 with duty_sh=0x00, so PWM channels stay low for the whole first period.
- Enable change → output change: 1 clk (outputs are registered).
- Duty change → waveform change: takes effect at the next period start. Worst case is 256 × CLK_DIV clks.
- Simultaneous duty write and period wrap: the value present on pwm_duty_cycle in the wrap cycle is captured.
- period_start:
  - Registered, high for exactly 1 clk.
  - Goes high in the cycle after the wrap, coincident with the first output cycle of the new period.
  - Never asserted during or on the cycle after reset.
- Reset mid-period: the period is abandoned. Outputs are 0 from the next edge and counting restarts from 0.
- Steady state: channel outputs change only on pwm_lvl transitions and enable changes, never more than twice per period per channel.

## Structure
- Shared package `pwm_pkg`:
  - PWM_STEPS = 256
  - DUTY_W = 8
  - DUTY_FULL = 8'hFF
  - NUM_CH = 16
- Sub-module `pwm_timebase`:
  - Contains the prescaler, pwm_cnt, duty_sh and the pwm_lvl/period-wrap outputs, parameterised by CLK_DIV.
  - The top level does the per-channel masking and output registering.
- Prescaler width is $clog2(CLK_DIV), minimum 1.

## Test plan
All scenarios use CLK_DIV=4 (period 1024 clks).
- Duty 0x80 on channel 0 (en_out=0x0001, en_pwm=0x0001) → out_7_0[0] high for 512 clks then low for 512 clks each period; all other bits 0; period_start every 1024 clks.
- Duty 0x00 → PWM channel constant 0. Duty 0xFF → constant 1 across ≥3 periods, with no single-cycle low at the wrap.
- en_out=0xFFFF, en_pwm=0x0000 → out_7_0=out_15_8=0xFF one clk after the write, regardless of duty. Then en_out_15_8=0x00 → out_15_8=0x00 one clk later.
- Duty 0x40 steady, then changed to 0xC0 at pwm_cnt=0x10 → current period keeps 256 clks high; the next period (after period_start) is 768 clks high.
- Assert rst at pwm_cnt=0x70 with duty 0xFF on all channels → all outputs 0 on the next edge. After release, the first period is all low (duty_sh=0), and the second period is constant high.
- en_out=0 with en_pwm=0xFFFF, duty 0x80 → outputs stay 0 for a full period.
